// File: rtl/perf_counter_bank_pkg.sv
// Shared definitions for the performance counter bank: config word layout,
// read-select encodings and the per-channel config record.
package perf_pkg;

  // Bit positions inside the config word written with wr_kind = 0.
  localparam int CFG_EN      = 0;
  localparam int CFG_SAT     = 1;
  localparam int CFG_EDGE    = 2;
  localparam int CFG_SEL_LSB = 3;

  // Widest event-select field any build may use (up to 255 event lines).
  // A package type cannot follow a module parameter, so the record reserves
  // this width. Channels only ever store their real SEL_W bits, which keeps
  // the spare upper bits at zero.
  localparam int SEL_MAX_W = 8;

  // Read-port selector encodings.
  typedef enum logic [1:0] {
    RD_LIVE   = 2'd0,
    RD_SHADOW = 2'd1,
    RD_CFG    = 2'd2,
    RD_OVF    = 2'd3
  } rd_sel_e;

  // Field order matches the config word bit layout, en at bit 0. A cast to
  // an integer therefore yields the readback value directly.
  typedef struct packed {
    logic [SEL_MAX_W-1:0] sel;
    logic                 edge_mode;
    logic                 sat;
    logic                 en;
  } cfg_t;

  // Address width for n counters, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// Write/read bus of the performance counter bank. The CPU side drives it as
// master and the counter bank answers as slave.
interface perf_counter_bank_if #(
  parameter int NUM_CNT = 4,
  parameter int CNT_W   = 32
);

  localparam int IDX_W = perf_pkg::idx_width(NUM_CNT);

  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic             wr_kind;
  logic [CNT_W-1:0] wr_data;
  logic [IDX_W-1:0] rd_addr;
  logic [1:0]       rd_sel;
  logic [CNT_W-1:0] rd_data;

  modport master (
    output wr_en, wr_addr, wr_kind, wr_data, rd_addr, rd_sel,
    input  rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_kind, wr_data, rd_addr, rd_sel,
    output rd_data
  );

endinterface

// File: rtl/perf_counter_bank_chan.sv
// One counter channel: live count, snapshot shadow, config record and sticky
// overflow flag. The parent selects the source line; the channel decides
// whether it produces a tick and how the count moves.
module perf_counter_chan
  import perf_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             src,
  input  logic             src_prev,
  input  logic             freeze,
  input  logic             snap,
  input  logic             wr_cfg,
  input  logic             wr_cnt,
  input  logic [CNT_W-1:0] wr_data,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] shadow,
  output logic [CNT_W-1:0] cfg_word,
  output logic [SEL_W-1:0] sel,
  output logic             ovf
);

  cfg_t             cfg_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] shadow_q;
  logic             ovf_q;
  logic             tick;
  logic             inc;
  logic             at_max;

  // Tick qualification: level mode counts every sampled high, edge mode only
  // the cycle where the source rose. Freeze blocks the increment alone.
  always_comb begin
    tick   = cfg_q.edge_mode ? (src & ~src_prev) : src;
    inc    = cfg_q.en & tick & ~freeze;
    at_max = &count_q;
  end

  // Live count and sticky overflow. A count write has priority over an
  // increment in the same cycle and also clears the overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (wr_cnt) begin
      count_q <= wr_data;
      ovf_q   <= 1'b0;
    end else if (inc) begin
      if (at_max) begin
        ovf_q <= 1'b1;
        if (!cfg_q.sat) begin
          count_q <= '0;
        end
      end else begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  // Snapshot takes the count as it stood before this edge, so neither a
  // same-cycle increment nor a same-cycle count write is captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
    end else if (snap) begin
      shadow_q <= count_q;
    end
  end

  // Config update becomes active on the next cycle. Only the real select
  // width is stored, so unused config bits read back as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_q <= '0;
    end else if (wr_cfg) begin
      cfg_q.en        <= wr_data[CFG_EN];
      cfg_q.sat       <= wr_data[CFG_SAT];
      cfg_q.edge_mode <= wr_data[CFG_EDGE];
      cfg_q.sel       <= SEL_MAX_W'(wr_data[CFG_SEL_LSB +: SEL_W]);
    end
  end

  assign count    = count_q;
  assign shadow   = shadow_q;
  assign cfg_word = CNT_W'(cfg_q);
  assign sel      = cfg_q.sel[SEL_W-1:0];
  assign ovf      = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Multi-channel performance counter bank. This level holds the event
// history, the per-channel source mux, the write decode and the
// combinational read mux. The counting itself lives in perf_counter_chan.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CNT = 4,
  parameter int CNT_W   = 32,
  parameter int NUM_EVT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               freeze_i,
  input  logic               snap_i,
  perf_counter_bank_if.slave bus,
  output logic [NUM_CNT-1:0] ovf_o
);

  localparam int SEL_W = $clog2(NUM_EVT + 1);
  localparam int IDX_W = idx_width(NUM_CNT);

  // Bit 0 stands for the built-in cycle tick, so select value k maps
  // straight onto bit k of these vectors.
  logic [NUM_EVT:0] evt_cur;
  logic [NUM_EVT:0] evt_q;

  logic [CNT_W-1:0] count    [NUM_CNT];
  logic [CNT_W-1:0] shadow   [NUM_CNT];
  logic [CNT_W-1:0] cfg_word [NUM_CNT];
  logic [SEL_W-1:0] sel      [NUM_CNT];
  logic [NUM_CNT-1:0] src;
  logic [NUM_CNT-1:0] src_prev;
  logic [NUM_CNT-1:0] wr_cfg;
  logic [NUM_CNT-1:0] wr_cnt;
  logic [NUM_CNT-1:0] ovf;
  logic [CNT_W-1:0]   rd_word;

  assign evt_cur = {evt_i, 1'b1};

  // Select values past the last event line match nothing and yield 0.
  function automatic logic pick_src(input logic [SEL_W-1:0] s,
                                    input logic [NUM_EVT:0] lines);
    logic r;
    r = 1'b0;
    for (int k = 0; k <= NUM_EVT; k++) begin
      if (s == SEL_W'(k)) begin
        r = lines[k];
      end
    end
    return r;
  endfunction

  // Previous-cycle sources for edge detection. Bit 0 clears on reset, so an
  // edge-mode cycle counter sees exactly one rising edge after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_cur;
    end
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_chan
    assign src[i]      = pick_src(sel[i], evt_cur);
    assign src_prev[i] = pick_src(sel[i], evt_q);
    assign wr_cfg[i]   = bus.wr_en & ~bus.wr_kind & (bus.wr_addr == IDX_W'(i));
    assign wr_cnt[i]   = bus.wr_en &  bus.wr_kind & (bus.wr_addr == IDX_W'(i));

    perf_counter_chan #(
      .CNT_W (CNT_W),
      .SEL_W (SEL_W)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .src      (src[i]),
      .src_prev (src_prev[i]),
      .freeze   (freeze_i),
      .snap     (snap_i),
      .wr_cfg   (wr_cfg[i]),
      .wr_cnt   (wr_cnt[i]),
      .wr_data  (bus.wr_data),
      .count    (count[i]),
      .shadow   (shadow[i]),
      .cfg_word (cfg_word[i]),
      .sel      (sel[i]),
      .ovf      (ovf[i])
    );
  end

  // Read mux: the overflow vector ignores the address. Other selections
  // return 0 for an address with no counter behind it.
  always_comb begin
    rd_word = '0;
    if (bus.rd_sel == RD_OVF) begin
      rd_word = CNT_W'(ovf);
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (bus.rd_addr == IDX_W'(i)) begin
          case (bus.rd_sel)
            RD_LIVE:   rd_word = count[i];
            RD_SHADOW: rd_word = shadow[i];
            RD_CFG:    rd_word = cfg_word[i];
            default:   rd_word = '0;
          endcase
        end
      end
    end
  end

  assign bus.rd_data = rd_word;
  assign ovf_o       = ovf;

endmodule
